// File: rtl/gauss_octave_sched_if.sv
// Handshake bundle between the octave FIFOs, the shared Gaussian pipeline and the scheduler.
// The scheduler side uses the master modport; the FIFO/pipeline side uses slave.
interface gauss_octave_sched_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_din;
    logic [NREQ-1:0]   req_rd_en;
    logic [NREQ-1:0]   out_full;
    logic [NREQ-1:0]   out_wr_en;
    logic              g_clr;
    logic              g_valid;
    logic [7:0]        g_din;
    logic              busy;
    logic [1:0]        grant_id;
    logic              frame_done;
    logic [1:0]        frame_done_id;

    modport master (
        input  req_valid, req_din, out_full,
        output req_rd_en, out_wr_en, g_clr, g_valid, g_din,
               busy, grant_id, frame_done, frame_done_id
    );

    modport slave (
        output req_valid, req_din, out_full,
        input  req_rd_en, out_wr_en, g_clr, g_valid, g_din,
               busy, grant_id, frame_done, frame_done_id
    );
endinterface

// File: rtl/gauss_octave_sched.sv
// Frame-level round-robin scheduler sharing one Gaussian blur pipeline among NREQ octave streams.
// Each frame: clear, stream N pixels, flush PRIME zeros, write only the N valid outputs.
module gauss_octave_sched #(
    parameter int NREQ  = 3,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PRIME = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    gauss_octave_sched_if.master bus
);
    localparam int unsigned NREQ_U  = NREQ;
    localparam int          SW      = $clog2(IMG_W * IMG_H + PRIME);
    localparam logic [1:0]  LAST_ID = 2'(NREQ - 1);
    localparam logic [SW-1:0] PRIME_S = SW'(PRIME);

    typedef enum logic [2:0] {IDLE, GRANT, STREAM, FLUSH, DONE} state_t;

    state_t            state;
    logic [1:0]        rr_ptr;
    logic [SW-1:0]     step;
    logic [SW-1:0]     nsize;
    logic              sel_found;
    logic [1:0]        sel_id;
    logic              fire;
    logic [NREQ-1:0]   grant_oh;
    logic [8*NREQ-1:0] din_sh;

    // Frame sizes are constants per octave; only the selection is dynamic.
    function automatic logic [SW-1:0] frame_size(input logic [1:0] k);
        case (k)
            2'd0:    return SW'(IMG_W * IMG_H);
            2'd1:    return SW'((IMG_W >> 1) * (IMG_H >> 1));
            2'd2:    return SW'((IMG_W >> 2) * (IMG_H >> 2));
            default: return SW'((IMG_W >> 3) * (IMG_H >> 3));
        endcase
    endfunction

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            int unsigned idx;
            idx = (32'(rr_ptr) + i) % NREQ_U;
            if (!sel_found && |((bus.req_valid >> idx) & NREQ'(1))) begin
                sel_found = 1'b1;
                sel_id    = 2'(idx);
            end
        end
    end

    assign grant_oh = NREQ'(1) << bus.grant_id;
    assign din_sh   = bus.req_din >> {bus.grant_id, 3'b000};

    // Strobes are Mealy so an unstalled requester moves one pixel per cycle.
    always_comb begin
        fire          = 1'b0;
        bus.req_rd_en = '0;
        bus.out_wr_en = '0;
        bus.g_valid   = 1'b0;
        bus.g_din     = '0;
        case (state)
            STREAM: begin
                fire = |(bus.req_valid & grant_oh) && !(|(bus.out_full & grant_oh));
                if (fire) begin
                    bus.g_valid   = 1'b1;
                    bus.g_din     = din_sh[7:0];
                    bus.req_rd_en = grant_oh;
                    if (step >= PRIME_S) bus.out_wr_en = grant_oh;
                end
            end
            FLUSH: begin
                fire = !(|(bus.out_full & grant_oh));
                if (fire) begin
                    bus.g_valid = 1'b1;
                    if (step >= PRIME_S) bus.out_wr_en = grant_oh;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            step              <= '0;
            nsize             <= '0;
            bus.grant_id      <= '0;
            bus.busy          <= 1'b0;
            bus.frame_done    <= 1'b0;
            bus.frame_done_id <= '0;
            bus.g_clr         <= 1'b0;
        end else begin
            bus.g_clr      <= 1'b0;
            bus.frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        bus.grant_id <= sel_id;
                        nsize        <= frame_size(sel_id);
                        step         <= '0;
                        bus.g_clr    <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= GRANT;
                    end
                end
                GRANT: state <= STREAM;
                STREAM: begin
                    if (fire) begin
                        step <= step + 1'b1;
                        if (step == nsize - 1'b1) state <= FLUSH;
                    end
                end
                // step keeps counting through the flush so the write gate stays step>=PRIME.
                FLUSH: begin
                    if (fire) begin
                        step <= step + 1'b1;
                        if (step == nsize + PRIME_S - 1'b1) begin
                            state             <= DONE;
                            bus.frame_done    <= 1'b1;
                            bus.frame_done_id <= bus.grant_id;
                        end
                    end
                end
                DONE: begin
                    rr_ptr   <= (bus.grant_id == LAST_ID) ? 2'd0 : bus.grant_id + 2'd1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
